ring_output_arbiter: RTL

- Output-port scheduler for one ring-router output channel.
- Shares the channel between three requesters: clockwise input, counter-clockwise input and the local PE-side NIC.
- Holds one buffer per virtual channel (even/odd) and fills one buffer while draining the other, alternating with net_polarity.
- Round-robin arbitration gives every requester fair access.

---
 rtl/ring_output_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ring_output_arbiter.sv
// Output-port scheduler for one ring-router channel: round-robin fill of the
// even/odd VC buffers, alternating send/fill with net_polarity.
// Optional stall statistic built only when ROUTER_ARB_STALL_CNT_EN is defined.
module ring_output_arbiter #(
    parameter int DATA_W  = 64,
    parameter int NUM_REQ = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      net_polarity,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_grant,
    input  logic                      net_ro,
    output logic                      net_so,
    output logic [DATA_W-1:0]         net_do,
    output logic [15:0]               stall_cnt
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = PTR_W + 1;

    logic                send_sel;
    logic                fill_sel;
    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [PTR_W-1:0]    gnt_idx;
    logic [CW-1:0]       cand;
    logic                grant_fire;

    logic [1:0]          full_q, full_d;
    logic [DATA_W-1:0]   data_buf_q [2];
    logic [DATA_W-1:0]   data_buf_d [2];
    logic [PTR_W-1:0]    rr_ptr_q [2];
    logic [PTR_W-1:0]    rr_ptr_d [2];

    assign send_sel = net_polarity;
    assign fill_sel = ~net_polarity;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & (req_data[i*DATA_W + DATA_W - 1] == fill_sel);
        end
    end

    // Rotating scan from the fill VC's pointer; wrap is compare-and-subtract.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = CW'(rr_ptr_q[fill_sel]) + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && eligible[cand[PTR_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        req_grant = '0;
        if (reset && found && !full_q[fill_sel]) begin
            req_grant[gnt_idx] = 1'b1;
        end
    end

    assign grant_fire = |req_grant;
    assign net_so     = full_q[send_sel] & net_ro;
    assign net_do     = net_so ? data_buf_q[send_sel] : '0;

    always_comb begin
        full_d     = full_q;
        data_buf_d = data_buf_q;
        rr_ptr_d   = rr_ptr_q;
        if (net_so) begin
            full_d[send_sel] = 1'b0;
        end
        if (grant_fire) begin
            full_d[fill_sel]     = 1'b1;
            data_buf_d[fill_sel] = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
            rr_ptr_d[fill_sel]   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q        <= '0;
            data_buf_q[0] <= '0;
            data_buf_q[1] <= '0;
            rr_ptr_q[0]   <= '0;
            rr_ptr_q[1]   <= '0;
        end else begin
            full_q     <= full_d;
            data_buf_q <= data_buf_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef ROUTER_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where a ready packet is held back by the downstream.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (full_q[send_sel] && !net_ro && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
